// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op and FSM state encodings shared by the multiply/divide unit and the ALU bench.
package muldiv_unit_pkg;
    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;
    localparam logic [2:0] OP_REMU  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic op_signed(input logic [2:0] op);
        return op == OP_MULH || op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic op_mul(input logic [2:0] op);
        return op <= OP_MULHU;
    endfunction

    function automatic logic op_quot(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);
    assign result = neg ? -value : value;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide; MULDIV_EARLY_OUT_EN lets special cases skip CALC.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             z
);
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q, neg_r, div0, pre;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     msum, trial;
    logic [2*WIDTH-1:0] mul_next, div_next, fix_in, fixed;
    logic               fix_neg;
    logic [WIDTH-1:0]   res;
    logic               early;
    logic [WIDTH-1:0]   early_res;

    assign ready = state == S_IDLE;
    assign a_neg = op_signed(op) & data1[WIDTH-1];
    assign b_neg = op_signed(op) & data2[WIDTH-1];

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.value(data1), .neg(a_neg), .result(a_abs));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.value(data2), .neg(b_neg), .result(b_abs));

    // acc = {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
    assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? b_q : {WIDTH{1'b0}}};
    assign mul_next = {msum, acc[WIDTH-1:1]};
    assign trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    assign div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Low bits of a negated zero-extended value equal its WIDTH-bit negation, so one wide fixer serves all ops.
    assign fix_in  = op_mul(op_q) ? acc
                   : {{WIDTH{1'b0}}, op_quot(op_q) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH]};
    assign fix_neg = (op_q == OP_MULH || op_q == OP_DIV) ? neg_q : (op_q == OP_REM) && neg_r;

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix (.value(fix_in), .neg(fix_neg), .result(fixed));

    always_comb begin
        res = pre ? acc[WIDTH-1:0]
            : op_q == OP_RSVD ? {WIDTH{1'b0}}
            : (div0 && op_quot(op_q)) ? {WIDTH{1'b1}}
            : (op_q == OP_MULH || op_q == OP_MULHU) ? fixed[2*WIDTH-1:WIDTH]
            : fixed[WIDTH-1:0];
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic d0, ovf, mz;
    assign d0  = !op_mul(op) && op != OP_RSVD && data2 == '0;
    assign ovf = (op == OP_DIV || op == OP_REM) && data1 == {1'b1, {WIDTH-1{1'b0}}} && data2 == '1;
    assign mz  = op_mul(op) && (data1 == '0 || data2 == '0);
    assign early = d0 || ovf || mz || op == OP_RSVD;
    assign early_res = d0 ? (op_quot(op) ? {WIDTH{1'b1}} : data1)
                     : (ovf && op == OP_DIV) ? {1'b1, {WIDTH-1{1'b0}}}
                     : {WIDTH{1'b0}};
`else
    assign early = 1'b0;
    assign early_res = {WIDTH{1'b0}};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            b_q   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            pre   <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            z     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_q  <= op;
                    b_q   <= b_abs;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    div0  <= data2 == '0;
                    cnt   <= CNT_W'(WIDTH);
                    pre   <= early;
                    acc   <= {{WIDTH{1'b0}}, early ? early_res : a_abs};
                    state <= early ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    cnt   <= cnt - CNT_W'(1);
                    acc   <= op_mul(op_q) ? mul_next : div_next;
                    state <= cnt == CNT_W'(1) ? S_FIX : S_CALC;
                end
                S_FIX: begin
                    out   <= res;
                    z     <= res == '0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] data1 = '0;
    logic [W-1:0] data2 = '0;
    logic         ready, done, z;
    logic [W-1:0] out;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .data1(data1), .data2(data2), .ready(ready), .done(done), .out(out), .z(z)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ps;
        logic [63:0] pu;
        logic ovf;
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        pu = {32'b0, a} * {32'b0, b};
        ovf = a == MIN && b == '1;
        case (o)
            3'd0: return ps[31:0];
            3'd1: return ps[63:32];
            3'd2: return pu[63:32];
            3'd3: begin
                if (b == 0) return '1;
                if (ovf) return MIN;
                return W'(sa / sb);
            end
            3'd4: begin
                if (b == 0) return '1;
                return a / b;
            end
            3'd5: begin
                if (b == 0) return a;
                if (ovf) return '0;
                return W'(sa % sb);
            end
            3'd6: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return '0;
        endcase
    endfunction

    // Edges after the accept edge until done is visible.
    function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (o == 3'd7) return 1;
        if (o <= 3'd2 && (a == 0 || b == 0)) return 1;
        if (o >= 3'd3 && b == 0) return 1;
        if ((o == 3'd3 || o == 3'd5) && a == MIN && b == '1) return 1;
`endif
        return W + 1;
    endfunction

    // Called mid-cycle while ready is high; returns once done is seen or the bound expires.
    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic rz, output int lat, output logic rdy_low);
        start = 1'b1;
        op = o;
        data1 = a;
        data2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom);
        data1 = $urandom;
        data2 = $urandom;
        lat = 0;
        rdy_low = 1'b1;
        while (lat < 100) begin
            if (ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        r = out;
        rz = z;
    endtask

    task automatic run_table(input string name, input vec_t t[$]);
        logic [W-1:0] r;
        logic rz, rl;
        int lat;
        foreach (t[i]) begin
            run(t[i].o, t[i].a, t[i].b, r, rz, lat, rl);
            checks++;
            if (r !== t[i].r) begin
                errors++;
                $display("FAIL %s[%0d] out: got %h want %h", name, i, r, t[i].r);
            end
            checks++;
            if (rz !== (t[i].r == 0)) begin
                errors++;
                $display("FAIL %s[%0d] z: got %b want %b", name, i, rz, t[i].r == 0);
            end
            checks++;
            if (lat != exp_lat(t[i].o, t[i].a, t[i].b) || !rl) begin
                errors++;
                $display("FAIL %s[%0d] latency: got %0d ready_low=%b want %0d ready_low=1",
                         name, i, lat, rl, exp_lat(t[i].o, t[i].a, t[i].b));
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || out !== '0 || z !== 1'b1) begin
            errors++;
            $display("FAIL reset: got ready=%b done=%b out=%h z=%b want 1 0 0 1", ready, done, out, z);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        vec_t t[$];
        t = '{'{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
              '{3'd1, MIN, MIN, 32'h4000_0000},
              '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
              '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0}};
        run_table("mul", t);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_div();
        vec_t t[$];
        t = '{'{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
              '{3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
              '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC},
              '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'd1}};
        run_table("div", t);
    endtask

    task automatic test_special();
        vec_t t[$];
        t = '{'{3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF},
              '{3'd5, 32'd5, 32'd0, 32'd5},
              '{3'd3, MIN, 32'hFFFF_FFFF, MIN},
              '{3'd5, MIN, 32'hFFFF_FFFF, 32'd0},
              '{3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF},
              '{3'd4, 32'd9, 32'd3, 32'd3},
              '{3'd7, 32'd12, 32'd34, 32'd0},
              '{3'd0, 32'd0, 32'd99, 32'd0}};
        run_table("special", t);
    endtask

    task automatic test_ignore_start();
        int lat;
        start = 1'b1;
        op = 3'd0;
        data1 = 32'd7;
        data2 = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            if (lat == 5) begin
                start = 1'b1;
                op = 3'd4;
                data1 = 32'd1;
                data2 = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        checks++;
        if (out !== 32'hFFFF_FFEB || lat != W + 1) begin
            errors++;
            $display("FAIL ignore_start: got out=%h lat=%0d want %h lat=%0d", out, lat, 32'hFFFF_FFEB, W + 1);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] r;
        logic rz, rl, seen;
        int lat;
        run(3'd0, 32'd7, 32'd9, r, rz, lat, rl);
        start = 1'b1;
        op = 3'd3;
        data1 = 32'd1000;
        data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || out !== '0 || z !== 1'b1) begin
            errors++;
            $display("FAIL abort: got ready=%b done=%b out=%h z=%b want 1 0 0 1", ready, done, out, z);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        checks++;
        if (seen !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL abort_no_done: got done_seen=%b out=%h want 0 0", seen, out);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r;
        logic rz, rl, hs;
        int lat;
        run(3'd0, 32'd3, 32'd5, r, rz, lat, rl);
        hs = ready & done;
        checks++;
        if (hs !== 1'b1 || r !== 32'd15) begin
            errors++;
            $display("FAIL b2b_first: got ready&done=%b out=%h want 1 %h", hs, r, 32'd15);
        end
        run(3'd3, 32'hFFFF_FF9C, 32'd7, r, rz, lat, rl);
        checks++;
        if (r !== model(3'd3, 32'hFFFF_FF9C, 32'd7) || lat != W + 1) begin
            errors++;
            $display("FAIL b2b_second: got out=%h lat=%0d want %h lat=%0d",
                     r, lat, model(3'd3, 32'hFFFF_FF9C, 32'd7), W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, e;
        logic [2:0] o;
        logic rz, rl;
        int lat, k;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 6);
            if (k == 0) b = '0;
            if (k == 1) begin
                a = MIN;
                b = '1;
            end
            if (k == 2) begin
                a = W'($urandom_range(0, 40)) - 32'd20;
                b = W'($urandom_range(0, 12)) - 32'd6;
            end
            if (k == 3) a = '0;
            e = model(o, a, b);
            run(o, a, b, r, rz, lat, rl);
            checks++;
            if (r !== e || rz !== (e == 0) || lat != exp_lat(o, a, b) || !rl) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got out=%h z=%b lat=%0d rl=%b want %h %b %0d 1",
                         i, o, a, b, r, rz, lat, rl, e, e == 0, exp_lat(o, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
